// File: rtl/router_output_arbiter.sv
// router_output_arbiter: round-robin, packet-locked output channel arbiter.
// Optional stall timeout is built when ROUTER_ARB_TIMEOUT_EN is defined.
module router_output_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int FLIT_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] in_flit,
    input  logic [NUM_REQ-1:0]            in_tail,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    output logic [FLIT_WIDTH-1:0]         out_flit,
    output logic                          out_tail,
    input  logic                          out_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          timeout
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] grant_nxt;
    logic           found;
    logic           any_req;
    logic           xfer;
    logic           stall_hit;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    assign any_req   = |in_valid;
    assign grant_nxt = wrap_add(grant_q, 1);
    assign busy      = (state_q == LOCKED);
    assign grant_id  = grant_q;

    // First requester at or above the rotation pointer, wrapping around
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && in_valid[wrap_add(rr_q, k)]) begin
                pick  = wrap_add(rr_q, k);
                found = 1'b1;
            end
        end
    end

    // Flit and handshake mux toward the owning requester
    always_comb begin
        in_ready           = '0;
        in_ready[grant_q]  = busy & out_ready;
        out_valid          = busy & in_valid[grant_q];
        out_tail           = busy & in_tail[grant_q];
        out_flit           = in_flit[int'(grant_q)*FLIT_WIDTH +: FLIT_WIDTH];
    end

    assign xfer = out_valid & out_ready;

    // Next-state: lock on arbitration, release on tail or forced release
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (stall_hit || (xfer && out_tail)) begin
                    state_d = IDLE;
                    rr_d    = grant_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant and rotation state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;

    assign stall_hit = busy && (stall_q == SW'(TIMEOUT_CYCLES));
    assign timeout   = timeout_q;

    // Count owner-starved cycles; downstream back-pressure is not a stall
    always_comb begin
        stall_d   = stall_q;
        timeout_d = stall_hit;
        if (!busy || xfer || stall_hit) begin
            stall_d = '0;
        end else if (!in_valid[grant_q]) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter and release pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign stall_hit          = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule
